// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch sequencer and the fetch datapath.
//   - state_t      : internal 3-bit FSM state (IDLE, LOAD, PRIME, RUN, HALT)
//   - STATE_O_*    : 2-bit debug encodings presented on state_o
//   - DEF_ADDR_W / DEF_INSTR_W : default PC and instruction widths
//   - jump_target  : jump destination formed from pc+1 and an instruction,
//                    shared by the datapath jump mux and the halt detector
package fetch_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_INSTR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_LOAD  = 3'b001,
    ST_PRIME = 3'b010,
    ST_RUN   = 3'b011,
    ST_HALT  = 3'b100
  } state_t;

  // HALT deliberately shares the IDLE code; halted tells them apart.
  localparam logic [1:0] STATE_O_IDLE  = 2'b00;
  localparam logic [1:0] STATE_O_LOAD  = 2'b01;
  localparam logic [1:0] STATE_O_PRIME = 2'b10;
  localparam logic [1:0] STATE_O_RUN   = 2'b11;
  localparam logic [1:0] STATE_O_HALT  = 2'b00;

  // A jump keeps the top two bits of pc+1 (the current 64-word page)
  // and takes the low six bits from the instruction.
  function automatic logic [DEF_ADDR_W-1:0] jump_target(
    input logic [DEF_ADDR_W-1:0]  pc_plus1,
    input logic [DEF_INSTR_W-1:0] instr
  );
    return {pc_plus1[DEF_ADDR_W-1:6], instr[5:0]};
  endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// sat_counter: saturating up-counter.
//   clk   : clock
//   rst   : synchronous active-low reset, clears the count
//   clr   : synchronous clear (wins over inc)
//   inc   : count up by one, holding at all-ones
//   count : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM for the fetch datapath.
//   clk, rst                 : clock, synchronous active-low reset
//   load_req                 : start a program load (IDLE, RUN, HALT)
//   load_valid/data/last     : program byte stream, load_ready is the ready
//   run_start                : start execution at address 0 without loading
//   run_stall                : downstream stall, freezes the PC
//   pc, instr                : current PC and the instruction it addresses
//   imem_we/waddr/wdata      : instruction memory write port
//   pc_en, pc_clr            : PC register load enable / clear to 0
//   fetch_valid              : instr is issued this cycle
//   halted                   : FSM sits in HALT (jump-to-self seen)
//   retired                  : saturating count of issued instructions
//   state_o                  : 2-bit debug state (HALT reads as IDLE)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               run_start,
  input  logic               run_stall,
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               pc_en,
  output logic               pc_clr,
  output logic               fetch_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   retired,
  output logic [1:0]         state_o
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   wptr_reg, wptr_next;
  logic [ADDR_W-1:0]   pc_plus1;
  logic                halt_hit;
  logic                issue;
  logic                retire_inc;
  logic                retire_clr;

  assign pc_plus1 = pc + ADDR_W'(1);

  // Jump-to-self: a jump whose target equals the current PC.
  assign halt_hit = instr[7] && (jump_target(pc_plus1, instr) == pc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      wptr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    wptr_next   = wptr_reg;
    load_ready  = 1'b0;
    imem_we     = 1'b0;
    imem_waddr  = wptr_reg;
    imem_wdata  = load_data;
    pc_en       = 1'b0;
    pc_clr      = 1'b0;
    fetch_valid = 1'b0;
    issue       = 1'b0;
    retire_inc  = 1'b0;
    retire_clr  = 1'b0;

    if (!rst) begin
      // While reset is held the outputs look like IDLE, so a byte
      // presented mid-LOAD during reset is never written.
      pc_clr = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          pc_clr = 1'b1;
          if (load_req) begin
            state_next = ST_LOAD;
            wptr_next  = '0;
          end else if (run_start) begin
            state_next = ST_PRIME;
          end
        end

        ST_LOAD: begin
          load_ready = 1'b1;
          if (load_valid) begin
            imem_we   = 1'b1;
            wptr_next = wptr_reg + ADDR_W'(1);  // wraps to 0 after the top address
            if (load_last || (wptr_reg == '1)) begin
              state_next = ST_PRIME;
            end
          end
        end

        ST_PRIME: begin
          pc_clr     = 1'b1;
          retire_clr = 1'b1;
          state_next = ST_RUN;
        end

        ST_RUN: begin
          issue       = !run_stall;
          fetch_valid = issue;
          pc_en       = issue && !halt_hit;
          retire_inc  = issue;
          // Halt beats a simultaneous load request; the load is taken
          // from HALT on the following cycle if still asserted.
          if (halt_hit) begin
            state_next = ST_HALT;
          end else if (load_req) begin
            state_next = ST_LOAD;
            wptr_next  = '0;
          end
        end

        ST_HALT: begin
          if (load_req) begin
            state_next = ST_LOAD;
            wptr_next  = '0;
          end else if (run_start) begin
            state_next = ST_PRIME;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Debug outputs decoded straight from the state register.
  always_comb begin
    case (state_reg)
      ST_LOAD:  state_o = STATE_O_LOAD;
      ST_PRIME: state_o = STATE_O_PRIME;
      ST_RUN:   state_o = STATE_O_RUN;
      ST_HALT:  state_o = STATE_O_HALT;
      default:  state_o = STATE_O_IDLE;
    endcase
  end

  assign halted = (state_reg == ST_HALT);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_retired (
    .clk   (clk),
    .rst   (rst),
    .clr   (retire_clr),
    .inc   (retire_inc),
    .count (retired)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the fetch datapath (PC register, imem,
// jump mux) around the sequencer and scoreboards every memory write.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_req, load_valid, load_last, run_start, run_stall;
  logic [7:0]  load_data;
  logic        load_ready;
  logic [7:0]  pc = 8'd0;
  logic [7:0]  instr;
  logic        imem_we;
  logic [7:0]  imem_waddr, imem_wdata;
  logic        pc_en, pc_clr, fetch_valid, halted;
  logic [15:0] retired;
  logic [1:0]  state_o;

  logic [7:0]  imem [256];
  logic [7:0]  pc_p1, next_pc;
  logic        tb_clear;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t wq[$];

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic [7:0] addr;
    logic       exp_ready;
    logic       exp_we;
    logic [1:0] exp_state;
  } load_vec_t;
  load_vec_t vec [5];

  fetch_sequencer #(.ADDR_W(8), .INSTR_W(8), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_req    (load_req),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .run_start   (run_start),
    .run_stall   (run_stall),
    .pc          (pc),
    .instr       (instr),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .pc_en       (pc_en),
    .pc_clr      (pc_clr),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .retired     (retired),
    .state_o     (state_o)
  );

  // Fetch datapath model.
  assign instr   = imem[pc];
  assign pc_p1   = pc + 8'd1;
  assign next_pc = instr[7] ? {pc_p1[7:6], instr[5:0]} : pc_p1;

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 256; i++) imem[i] <= 8'h00;
    end else if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
    if (pc_clr)     pc <= 8'd0;
    else if (pc_en) pc <= next_pc;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  // Negative-edge sample point; also the scoreboard monitor.
  task automatic neg();
    wr_t e;
    @(negedge clk);
    if (imem_we) begin
      if (wq.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected_write: got addr %0d data %0d, required no write",
                 imem_waddr, imem_wdata);
      end else begin
        e = wq.pop_front();
        check("sb_waddr", imem_waddr, e.addr);
        check("sb_wdata", imem_wdata, e.data);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0] = '{1'b1, 8'h10, 1'b0, 8'd0, 1'b1, 1'b1, 2'd1};
    vec[1] = '{1'b0, 8'hEE, 1'b0, 8'd0, 1'b1, 1'b0, 2'd1};
    vec[2] = '{1'b1, 8'h11, 1'b0, 8'd1, 1'b1, 1'b1, 2'd1};
    vec[3] = '{1'b1, 8'h83, 1'b0, 8'd2, 1'b1, 1'b1, 2'd1};
    vec[4] = '{1'b1, 8'h83, 1'b1, 8'd3, 1'b1, 1'b1, 2'd2};

    rst = 1'b0; tb_clear = 1'b1;
    load_req = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 8'h00;
    run_start = 1'b0; run_stall = 1'b0;

    // Reset state
    neg(); step(); tb_clear = 1'b0;
    neg();
    check("rst_pc_clr", pc_clr, 1);
    check("rst_load_ready", load_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_halted", halted, 0);
    check("rst_state", state_o, 0);
    check("rst_retired", retired, 0);
    step();
    rst = 1'b1;

    // Load then run, table driven
    load_req = 1'b1;
    neg(); check("idle_pc_clr", pc_clr, 1);
    step(); load_req = 1'b0;
    check("enter_load", state_o, 1);
    for (int i = 0; i < 5; i++) begin
      load_valid = vec[i].valid; load_data = vec[i].data; load_last = vec[i].last;
      if (vec[i].exp_we) push_wr(vec[i].addr, vec[i].data);
      neg();
      check("vec_ready", load_ready, vec[i].exp_ready);
      check("vec_we", imem_we, vec[i].exp_we);
      step();
      check("vec_state", state_o, vec[i].exp_state);
    end
    load_valid = 1'b0; load_last = 1'b0;
    neg();
    check("prime_fv", fetch_valid, 0);
    check("prime_pc_clr", pc_clr, 1);
    step();
    neg();
    check("run0_state", state_o, 3);
    check("run0_fv", fetch_valid, 1);
    check("run0_pc", pc, 0);
    check("run0_pc_en", pc_en, 1);
    check("run0_retired", retired, 0);
    step();
    neg(); check("run1_pc", pc, 1); check("run1_retired", retired, 1);
    step();

    // Stall for 3 cycles at pc 2
    run_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      neg();
      check("stall_fv", fetch_valid, 0);
      check("stall_pc_en", pc_en, 0);
      check("stall_pc", pc, 2);
      check("stall_retired", retired, 2);
      step();
    end
    run_stall = 1'b0;
    neg(); check("resume_fv", fetch_valid, 1); check("resume_pc", pc, 2); check("resume_pc_en", pc_en, 1);
    step();

    // Halt at pc 3 (instr 8'h83)
    neg();
    check("halt_pc", pc, 3);
    check("halt_fv", fetch_valid, 1);
    check("halt_pc_en", pc_en, 0);
    check("halt_pre", halted, 0);
    step();
    check("halt_halted", halted, 1);
    check("halt_retired", retired, 4);
    check("halt_state", state_o, 0);
    neg(); step(); neg();
    check("halt_pc_hold", pc, 3);
    check("halt_pc_clr", pc_clr, 0);
    step();

    // Restart from HALT; halt_hit and load_req together
    run_start = 1'b1;
    neg(); step(); run_start = 1'b0;
    check("restart_prime", state_o, 2);
    neg(); step();
    check("restart_run", state_o, 3);
    check("restart_retired", retired, 0);
    neg(); step(); neg(); step(); neg(); step();
    load_req = 1'b1;
    neg(); check("simul_pc", pc, 3); check("simul_state", state_o, 3);
    step();
    check("simul_halt_state", state_o, 0);
    check("simul_halted", halted, 1);
    check("simul_retired", retired, 4);
    neg(); step();
    check("simul_load_state", state_o, 1);
    check("simul_load_halted", halted, 0);
    load_req = 1'b0;

    // Reset mid-LOAD
    load_valid = 1'b1; load_data = 8'h01; push_wr(8'd0, 8'h01);
    neg(); step();
    load_data = 8'h02; push_wr(8'd1, 8'h02);
    neg(); step();
    rst = 1'b0; load_data = 8'h55;
    neg();
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_ready", load_ready, 0);
    check("mid_rst_pc_clr", pc_clr, 1);
    step();
    rst = 1'b1; load_valid = 1'b0;
    check("mid_rst_state", state_o, 0);
    check("mid_rst_retired", retired, 0);
    check("mid_rst_halted", halted, 0);
    neg();
    check("mid_rst_mem2", imem[2], 8'h83);
    check("mid_rst_mem1", imem[1], 8'h02);
    step();

    // run_start from IDLE, then load_req during a stall
    run_start = 1'b1;
    neg(); step(); run_start = 1'b0;
    check("start_prime", state_o, 2);
    neg(); check("start_n1_fv", fetch_valid, 0);
    step();
    neg(); check("start_n2_fv", fetch_valid, 1); check("start_n2_pc", pc, 0);
    step();
    run_stall = 1'b1; load_req = 1'b1;
    neg(); check("abort_fv", fetch_valid, 0); check("abort_pc_en", pc_en, 0); check("abort_pc", pc, 1);
    step();
    check("abort_state", state_o, 1);
    run_stall = 1'b0; load_req = 1'b0;

    // Full-memory wrap without load_last
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'(i) ^ 8'hA5;
      load_valid = 1'b1; load_data = d;
      push_wr(8'(i), d);
      neg(); check("wrap_ready", load_ready, 1);
      step(); check("wrap_state", state_o, (i == 255) ? 2 : 1);
    end
    load_data = 8'hEE;
    neg(); check("wrap_257_ready", load_ready, 0); check("wrap_257_we", imem_we, 0);
    step();
    load_valid = 1'b0;
    check("wrap_run", state_o, 3);
    neg();
    check("wrap_mem0", imem[0], 8'hA5);
    check("wrap_mem255", imem[255], 8'h5A);
    check("wrap_pc", pc, 0);
    load_req = 1'b1;
    step(); load_req = 1'b0;
    check("reload_state", state_o, 1);
    load_valid = 1'b1; load_last = 1'b1; load_data = 8'h77; push_wr(8'd0, 8'h77);
    neg(); check("reload_waddr", imem_waddr, 0);
    step();
    load_valid = 1'b0; load_last = 1'b0;
    check("reload_prime", state_o, 2);
    neg(); step();
    neg(); check("reload_mem0", imem[0], 8'h77);
    step();

    check("sb_drain", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM that owns the fetch datapath: PC register, instruction memory, PC+1 adder and jump mux.
- Loads a program into instruction memory over a byte-stream valid/ready handshake, holding the PC idle while it does.
- Then releases the PC, gates PC advance on downstream stall, and detects the jump-to-self halt idiom.
- Sits between the external loader/testbench and the fetch datapath. Drives the PC enable/clear and the memory write port.

## Interface
Parameters:
- ADDR_W, 8, instruction address width (PC width)
- INSTR_W, 8, instruction width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- load_req  in  1  request program load; honoured in IDLE, HALT and RUN
- load_valid  in  1  load_data valid
- load_data  in  INSTR_W  program byte
- load_last  in  1  marks final byte of program
- load_ready  out  1  sequencer accepts a byte this cycle
- run_start  in  1  start execution from address 0 without loading
- run_stall  in  1  downstream stall; freezes the PC
- pc  in  ADDR_W  current PC value from PC register
- instr  in  INSTR_W  instruction at pc, read combinationally from imem
- imem_we  out  1  instruction memory write enable
- imem_waddr  out  ADDR_W  write address
- imem_wdata  out  INSTR_W  write data
- pc_en  out  1  PC register loads next address
- pc_clr  out  1  PC register forced to 0 on next edge
- fetch_valid  out  1  instr is a valid issued instruction this cycle
- halted  out  1  sequencer in HALT
- retired  out  CNT_W  count of issued instructions, saturating
- state_o  out  2  encoded state, for debug

## Operation
States (2-bit encoding):

| State | Code | Outputs | Transitions |
|---|---|---|---|
| IDLE | 00 | pc_clr=1 | load_req → LOAD (load_req has priority); run_start → PRIME |
| LOAD | 01 | load_ready=1 | Handshake fires when load_valid & load_ready: imem_we=1, imem_waddr=wptr, imem_wdata=load_data, wptr++. Handshake with load_last=1, or with wptr==2^ADDR_W-1 → PRIME (wptr wraps to 0 on that beat). |
| PRIME | 10 | pc_clr=1, fetch_valid=0 | Unconditional next cycle → RUN; clears retired to 0 |
| RUN | 11 | see below | halt_hit → HALT; load_req → LOAD, aborting execution |
| HALT | 00 + halted | halted=1, pc_en=0 | load_req → LOAD; run_start → PRIME |

RUN behaviour:
- fetch_valid = !run_stall.
- halt_hit = instr[7] & ({pc_plus1[7:6], instr[5:0]} == pc), where pc_plus1 = pc+1 modulo 2^ADDR_W. This is a jump-to-self.
- pc_en = fetch_valid & !halt_hit.
- retired increments on every fetch_valid cycle, including the halting instruction, and saturates at all-ones.
- If halt_hit and load_req occur together, HALT wins. load_req is then honoured in HALT the next cycle.
- A load_req arriving with run_stall=1 still aborts the run.

HALT encoding:
- state_o reads 00 in both IDLE and HALT. The halted output distinguishes them.
- This keeps state_o at 2 bits; internally the FSM uses a 3-bit state.

Registers and reset:
- wptr is an ADDR_W register. It is cleared to 0 on entry to LOAD.
- A byte with load_valid=1 outside LOAD is ignored and never written.
- Reset (rst=0 at an edge), from any state including mid-LOAD, gives: state IDLE, wptr 0, retired 0.
- Memory contents already written are not erased.

## Timing
Reset values:
- Combinational outputs resolve to their IDLE values: load_ready 0, imem_we 0, pc_en 0, pc_clr 1, fetch_valid 0, halted 0.
- retired 0, state_o 00.

Output timing:
- load_ready, imem_we, pc_en, pc_clr and fetch_valid are combinational from state and inputs (Mealy).
- retired, halted and state_o are registered.

Load and start latency:
- Load throughput: one byte per cycle.
- Last handshake at edge N → PRIME during cycle N+1 → RUN in cycle N+2 with pc = 0.
- First fetch_valid occurs in that cycle if run_stall=0.
- From IDLE, run_start sampled at edge N gives the first fetch_valid in cycle N+2.

Stall and halt:
- Stall: pc_en falls in the same cycle as run_stall; PC holds.
- Halt: halt_hit at edge N sets halted from cycle N+1; pc never changes after edge N.

## Structure
Shared package fetch_pkg holds:
- The state enum (IDLE, LOAD, PRIME, RUN, HALT) and STATE_O encoding constants.
- ADDR_W and INSTR_W defaults.
- Function jump_target(pc_plus1, instr), returning {pc_plus1[7:6], instr[5:0]}. The jump mux and this block both use it.

Sub-module:
- One natural sub-module: sat_counter (parameter width, inc, clr), used for retired.
- FSM and wptr stay inline.

## Test plan
- **Reset mid-LOAD:** load bytes 8'h01, 8'h02, then assert rst=0 for one edge → IDLE, pc_clr=1, retired=0; address 2 was not written.
- **Load then run:** stream 8'h10, 8'h11, 8'h83 with last on the third byte → imem[0..2] written; fetch_valid first high two cycles after the last beat at pc=0.
- **Halt detect:** with pc=3 and instr=8'h83 (pc_plus1[7:6]=00, target 3) → HALT next cycle, halted=1, retired=4 (pc 0,1,2,3).
- **Stall:** run_stall high for 3 cycles in RUN → pc_en=0 and fetch_valid=0 for exactly those cycles; retired unchanged; PC resumes on the next edge.
- **Full-memory wrap:** stream 256 bytes with load_last never asserted → auto-exit to PRIME after address 255; wptr returns to 0; the 257th byte is not accepted.
- **Simultaneous events:** halt_hit and load_req in the same cycle → HALT first, then LOAD one cycle later. Also, load_req with run_stall=1 in RUN → LOAD next cycle.
